// File: rtl/ms_delay_timer.sv
// ----------------------------------------------------------------------------
// ms_delay_timer
//
// Programmable millisecond delay timer. It counts 1 ms ticks from the LFSR
// millisecond tick generator and pulses `done` when the requested number of
// milliseconds has elapsed. It also drives the generator enable (`tick_en`),
// so the generator runs only while a delay is actively counting.
//
// Optional feature macro: MS_DELAY_AUTORELOAD_EN
//   defined   : periodic mode. On completion the count reloads from the
//               latched duration and the timer keeps running. Only abort or
//               reset returns it to IDLE.
//   undefined : one-shot mode. Completion returns the timer to IDLE.
//
// Ports
//   clk        in   system clock (50 MHz)
//   rst        in   synchronous reset, active-low
//   ms_tick    in   one-cycle pulse per elapsed millisecond
//   start      in   one-cycle request, latches `duration` (ignored unless IDLE)
//   duration   in   requested delay in ms (DW bits)
//   pause      in   level, freezes the countdown while high
//   abort      in   one-cycle cancel, overrides every other request
//   tick_en    out  tick generator enable, high only while RUN
//   busy       out  high while RUN or PAUSE
//   done       out  one-cycle completion pulse
//   remaining  out  milliseconds left in the current delay (DW bits)
//
// All outputs are registered. Request priority at each edge is:
// rst, abort, start, pause, ms_tick.
// ----------------------------------------------------------------------------
module ms_delay_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ms_tick,
  input  logic          start,
  input  logic [DW-1:0] duration,
  input  logic          pause,
  input  logic          abort,
  output logic          tick_en,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [DW-1:0] zero_c = {DW{1'b0}};
  localparam logic [DW-1:0] one_c  = {{(DW-1){1'b0}}, 1'b1};

  state_t          state_r;
  state_t          state_s;
  logic [DW-1:0]   remaining_r;
  logic [DW-1:0]   remaining_s;
  logic [DW-1:0]   dur_r;
  logic [DW-1:0]   dur_s;
  logic            done_r;
  logic            done_s;
  logic            busy_r;
  logic            tick_en_r;

  // Next-state, next-count and completion decode.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    dur_s       = dur_r;
    done_s      = 1'b0;

    if (abort) begin
      // Cancel never produces a completion pulse.
      state_s     = IDLE;
      remaining_s = zero_c;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dur_s = duration;
            if (duration != zero_c) begin
              state_s     = RUN;
              remaining_s = duration;
            end else begin
              // A zero-length delay completes immediately without running.
              state_s     = IDLE;
              done_s      = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end

        RUN: begin
          if (pause) begin
            // The tick sampled on the pausing edge is deliberately dropped.
            state_s = PAUSE;
          end else if (ms_tick) begin
            if (remaining_r > one_c) begin
              remaining_s = remaining_r - one_c;
            end else if (remaining_r == one_c) begin
              done_s = 1'b1;
`ifdef MS_DELAY_AUTORELOAD_EN
              // Latched duration is non-zero whenever RUN is reached.
              remaining_s = dur_r;
              state_s     = RUN;
`else
              remaining_s = zero_c;
              state_s     = IDLE;
`endif
            end else begin
              // Unreachable count of zero in RUN: park safely, never wrap.
              remaining_s = zero_c;
              state_s     = IDLE;
            end
          end else begin
            state_s = RUN;
          end
        end

        PAUSE: begin
          // Ticks are ignored while paused, including on the release edge.
          if (pause) begin
            state_s = PAUSE;
          end else begin
            state_s = RUN;
          end
        end

        default: begin
          state_s     = IDLE;
          remaining_s = zero_c;
        end
      endcase
    end
  end

  // State, count and registered output flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      remaining_r <= zero_c;
      dur_r       <= zero_c;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      tick_en_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      dur_r       <= dur_s;
      done_r      <= done_s;
      // Flags follow the next state so they change in the same cycle as it.
      busy_r      <= (state_s != IDLE);
      tick_en_r   <= (state_s == RUN);
    end
  end

  assign tick_en   = tick_en_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = remaining_r;

endmodule

// File: tb/tb_ms_delay_timer.sv
// ----------------------------------------------------------------------------
// tb_ms_delay_timer
//
// Self-checking bench for ms_delay_timer. A driver applies directed and
// random stimulus on the falling edge and advances an abstract reference
// model (active/paused flags and an integer count of milliseconds left).
// Each predicted completion is queued with the cycle on which `done` must
// appear; an independent monitor pops and compares whenever `done` is seen.
// Build with +define+MS_DELAY_AUTORELOAD_EN to check the periodic variant.
// ----------------------------------------------------------------------------
module tb_ms_delay_timer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ms_tick = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] duration = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic          tick_en;
  logic          busy;
  logic          done;
  logic [DW-1:0] remaining;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  int mon_e;

  // Reference model state.
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  bit m_paused = 1'b0;
  int m_left   = 0;
  int m_period = 0;

  ms_delay_timer #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ms_tick   (ms_tick),
    .start     (start),
    .duration  (duration),
    .pause     (pause),
    .abort     (abort),
    .tick_en   (tick_en),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #10 clk = ~clk;

  // Cycle index, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: check the outputs produced by the previous edge,
  // drive new inputs, then advance the model across the coming edge.
  task automatic step(input logic r, input logic s, input logic [DW-1:0] d,
                      input logic p, input logic a, input logic t);
    @(negedge clk);
    if (m_valid) begin
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("tick_en", {31'd0, tick_en}, {31'd0, (m_active && !m_paused)});
      check("remaining", {16'd0, remaining}, 32'(m_left));
    end
    rst = r; start = s; duration = d; pause = p; abort = a; ms_tick = t;

    if (!r) begin
      m_active = 1'b0; m_paused = 1'b0; m_left = 0; m_period = 0; m_valid = 1'b1;
    end else if (a) begin
      m_active = 1'b0; m_paused = 1'b0; m_left = 0;
    end else if (!m_active) begin
      if (s) begin
        m_period = int'(d);
        if (d != '0) begin
          m_active = 1'b1; m_left = int'(d);
        end else begin
          exp_q.push_back(cyc + 1);
        end
      end
    end else if (m_paused) begin
      if (!p) m_paused = 1'b0;
    end else if (p) begin
      m_paused = 1'b1;
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        exp_q.push_back(cyc + 1);
`ifdef MS_DELAY_AUTORELOAD_EN
        m_left = m_period;
`else
        m_active = 1'b0;
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_abort();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  // Completion monitor: every done pulse must match the next predicted cycle.
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected cyc=%0d got=1 required=0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          fails++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, mon_e);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      tests++;
      fails++;
      $display("FAIL done_missed cyc=%0d required_at=%0d", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    logic          r_s, s_s, p_s, a_s, t_s;
    logic [DW-1:0] d_s;

    // Reset held two cycles with start asserted.
    step(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
    idle(3);

    // One-shot: duration 3, a tick every 10 cycles.
    step(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, ((i % 10) == 9) ? 1'b1 : 1'b0);
    do_abort();
    idle(3);

    // Zero duration completes at once and never goes busy.
    step(1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Pause after two ticks, held across three ticks, then released.
    step(1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 90; i++)
      step(1'b1, 1'b0, '0, (i >= 25 && i < 55) ? 1'b1 : 1'b0, 1'b0,
           ((i % 10) == 9) ? 1'b1 : 1'b0);
    do_abort();
    idle(3);

    // Abort during RUN at remaining 4, then abort and start together.
    step(1'b1, 1'b1, 16'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
    do_abort();
    idle(2);
    step(1'b1, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Start ignored while running; duration 2 with six ticks.
    step(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, ((i % 5) == 4) ? 1'b1 : 1'b0);
    do_abort();

    // Reset in the middle of a delay.
    step(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Random traffic.
    p_s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r_s = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      s_s = ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0;
      a_s = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      t_s = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 19) == 0) p_s = ~p_s;
      if ($urandom_range(0, 15) == 0) d_s = DW'($urandom_range(0, 65535));
      else                            d_s = DW'($urandom_range(0, 8));
      step(r_s, s_s, d_s, p_s, a_s, t_s);
    end

    do_abort();
    idle(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL done_pending got=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ms_delay_timer.md
# ms_delay_timer

Programmable millisecond delay timer that consumes the one-cycle 1 ms tick from the game's LFSR millisecond tick generator and signals when a requested number of milliseconds has elapsed. It drives that generator's enable, so the generator runs only while a delay is active. The sequence/display controllers use it for LED-on time, inter-symbol gaps and player-response timeouts.

## Interface
- DW, 16, width of duration/remaining count (max delay 2^DW−1 ms)

- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, synchronous, active-low
- ms_tick  in  1  one-cycle pulse per elapsed ms from the tick generator
- start  in  1  one-cycle request; latches `duration`
- duration  in  DW  requested delay in ms, sampled only with accepted `start`
- pause  in  1  level; freezes countdown while high
- abort  in  1  one-cycle cancel; highest priority after reset
- tick_en  out  1  enable to tick generator; high only in RUN
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse on delay completion
- remaining  out  DW  ms left in the current delay

## Operation
- States: IDLE, RUN, PAUSE. All outputs registered.
- Reset (rst=0 at an edge): state IDLE, remaining=0, latched duration=0, done=0, busy=0, tick_en=0.
- Priority at each edge: rst, then abort, then start, then pause, then ms_tick.
- IDLE:
  - start=1, duration≠0 → RUN; remaining=duration; duration latched.
  - start=1, duration=0 → stay IDLE; done=1 next cycle.
  - ms_tick ignored.
- RUN:
  - pause=1 → PAUSE; tick sampled on that edge ignored.
  - Otherwise ms_tick=1 with remaining>1 → remaining−1.
  - ms_tick=1 with remaining=1 → remaining=0, done=1, state IDLE (see Configuration).
  - start ignored (no restart); abort required to re-arm.
- PAUSE: remaining held, ms_tick ignored; pause=0 → RUN.
- abort in any state → IDLE, remaining=0, no done pulse. abort and start on the same edge: abort wins, start dropped.
- done is high for exactly one cycle per completion and is never asserted by abort or reset.
- Arithmetic: unsigned DW-bit decrement; remaining never wraps below 0.

## Timing
- Start latency: start sampled at edge E0 → busy=1, tick_en=1, remaining=duration in the cycle after E0.
- Completion: the edge sampling the final ms_tick → done=1, busy=0, tick_en=0 in the following cycle.
- Total delay with a free-running 1 ms generator started by tick_en: N ms ±1 clk.
- pause/abort take effect at the next edge; tick_en drops in the same cycle busy changes.
- rst asserted mid-delay → IDLE at that edge, no done pulse.

## Configuration
- MS_DELAY_AUTORELOAD_EN defined: on completion remaining reloads from latched duration, state stays RUN, tick_en stays high, done pulses once per period; only abort or reset returns to IDLE. A latched duration of 0 never enters RUN.
- Undefined: one-shot; completion returns to IDLE as described above.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 → all outputs 0, state IDLE.
- One-shot: start with duration=3 and ms_tick pulsed every 10 cycles → remaining 3,2,1,0; single done pulse the cycle after the 3rd tick; busy=0 afterwards.
- Zero duration: start with duration=0 → done=1 for one cycle, busy never asserts, tick_en stays 0.
- Pause: duration=5, pause high after 2 ticks and held across 3 ticks → remaining holds at 3, tick_en=0; after release, done follows 3 more ticks.
- Abort vs start: abort during RUN at remaining=4 → IDLE, remaining=0, no done. abort+start on the same edge → stays IDLE.
- Autoreload (macro defined): duration=2, 6 ticks → 3 done pulses; busy stays 1 until abort.
